player_position_tracker: RTL and testbench

Downstream consumer of the PS/2 WASD decoder: takes its 2-bit left/right and up/down movement codes, brings them safely into the system clock domain, and steps a player coordinate pair at a fixed move rate. The block owns the authoritative (x, y) position that the display/game stages read. It clamps the position to the playfield bounds and flags each actual move.

---
 rtl/player_position_tracker.sv | 81 ++++++++
 tb/tb_player_position_tracker.sv | 120 ++++++++++++
 2 files changed

// File: rtl/player_position_tracker.sv
// player_position_tracker: synchronizes WASD direction codes and steps a bounded (x, y) position at a fixed tick rate.
// Define PLAYER_WRAP_EN to wrap coordinates at the playfield bounds instead of clamping.
module player_position_tracker #(
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int X_START  = 320,
  parameter int Y_START  = 240,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 500000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] leftRight,
  input  logic [1:0] upDown,
  input  logic       enable,
  output logic [9:0] xPos,
  output logic [9:0] yPos,
  output logic       moved,
  output logic [3:0] atEdge
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [10:0] S  = 11'(STEP);
  localparam logic [10:0] XM = 11'(X_MAX);
  localparam logic [10:0] YM = 11'(Y_MAX);
  logic [1:0] lr_s1, lr_s2, lr_q, ud_s1, ud_s2, ud_q;
  logic [CW-1:0] count;
  logic tick, mv;
  logic [10:0] x_w, y_w;
  logic [9:0] x_n, y_n;
  assign x_w  = {1'b0, xPos};
  assign y_w  = {1'b0, yPos};
  assign tick = enable && (count == CW'(TICK_DIV - 1));
  always_comb begin
`ifdef PLAYER_WRAP_EN
    x_n = lr_q == 2'd0 ? 10'(x_w >= S ? x_w - S : x_w + XM + 11'd1 - S)
        : lr_q == 2'd1 ? 10'(x_w + S <= XM ? x_w + S : x_w + S - XM - 11'd1)
        : xPos;
    y_n = ud_q == 2'd0 ? 10'(y_w >= S ? y_w - S : y_w + YM + 11'd1 - S)
        : ud_q == 2'd1 ? 10'(y_w + S <= YM ? y_w + S : y_w + S - YM - 11'd1)
        : yPos;
    mv  = tick && (lr_q < 2'd2 || ud_q < 2'd2);
`else
    x_n = lr_q == 2'd0 ? 10'(x_w >= S ? x_w - S : 11'd0)
        : lr_q == 2'd1 ? 10'(x_w + S <= XM ? x_w + S : XM)
        : xPos;
    y_n = ud_q == 2'd0 ? 10'(y_w >= S ? y_w - S : 11'd0)
        : ud_q == 2'd1 ? 10'(y_w + S <= YM ? y_w + S : YM)
        : yPos;
    mv  = tick && (x_n != xPos || y_n != yPos);
`endif
  end
  // qualified direction follows only a value seen on two consecutive synchronized samples
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lr_s1 <= 2'd2;
      lr_s2 <= 2'd2;
      lr_q  <= 2'd2;
      ud_s1 <= 2'd2;
      ud_s2 <= 2'd2;
      ud_q  <= 2'd2;
      count <= '0;
      xPos  <= 10'(X_START);
      yPos  <= 10'(Y_START);
      moved <= 1'b0;
    end else begin
      lr_s1 <= leftRight;
      lr_s2 <= lr_s1;
      ud_s1 <= upDown;
      ud_s2 <= ud_s1;
      if (lr_s1 == lr_s2) lr_q <= lr_s2;
      if (ud_s1 == ud_s2) ud_q <= ud_s2;
      count <= (!enable || tick) ? '0 : count + CW'(1);
      if (tick) begin
        xPos <= x_n;
        yPos <= y_n;
      end
      moved <= mv;
    end
  end
  assign atEdge = {xPos == 10'(X_MAX), xPos == 10'd0, yPos == 10'(Y_MAX), yPos == 10'd0};
endmodule

// File: tb/tb_player_position_tracker.sv
// tb_player_position_tracker: scoreboard bench; expected positions are queued and checked on each moved pulse.
module tb_player_position_tracker;
  logic clock, reset_n, enable, moved;
  logic [1:0] leftRight, upDown;
  logic [9:0] xPos, yPos;
  logic [3:0] atEdge;
  int tests = 0, fails = 0;
  typedef struct { int x; int y; } pos_t;
  pos_t q[$];

  player_position_tracker #(.X_MAX(15), .Y_MAX(11), .X_START(8), .Y_START(6), .STEP(2), .TICK_DIV(4)) dut (
    .clock(clock), .reset_n(reset_n), .leftRight(leftRight), .upDown(upDown),
    .enable(enable), .xPos(xPos), .yPos(yPos), .moved(moved), .atEdge(atEdge)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y);
    pos_t p;
    p.x = x;
    p.y = y;
    q.push_back(p);
  endtask

  always @(negedge clock) begin
    if (reset_n && moved) begin
      if (q.size() == 0) check("unexpected_move", 1, 0);
      else begin
        pos_t p;
        p = q.pop_front();
        check("move_x", int'(xPos), p.x);
        check("move_y", int'(yPos), p.y);
      end
    end
  end

  initial begin
    int n;
    clock = 0; reset_n = 0; enable = 0; leftRight = 2; upDown = 2;
    repeat (3) @(negedge clock);
    check("reset_x", int'(xPos), 8);
    check("reset_y", int'(yPos), 6);
    check("reset_moved", int'(moved), 0);
    check("reset_edge", int'(atEdge), 0);
    reset_n = 1; enable = 1;
    repeat (20) @(negedge clock);
    check("idle_x", int'(xPos), 8);
    check("idle_y", int'(yPos), 6);
`ifndef PLAYER_WRAP_EN
    push(10, 6); push(12, 6); push(14, 6); push(15, 6);
    leftRight = 1;
    repeat (40) @(negedge clock);
    check("right_x", int'(xPos), 15);
    check("right_edge", int'(atEdge), 4'b1000);
    check("right_pending", q.size(), 0);
    reset_n = 0; leftRight = 2;
    #1;
    check("async_x", int'(xPos), 8);
    check("async_moved", int'(moved), 0);
    @(negedge clock);
    reset_n = 1;
    push(6, 4); push(4, 2); push(2, 0); push(0, 0);
    leftRight = 0; upDown = 0;
    repeat (40) @(negedge clock);
    check("diag_x", int'(xPos), 0);
    check("diag_y", int'(yPos), 0);
    check("diag_edge", int'(atEdge), 4'b0101);
    check("diag_pending", q.size(), 0);
`else
    push(10, 6); push(12, 6); push(14, 6); push(0, 6);
    leftRight = 1;
    n = 0;
    do begin @(negedge clock); n++; end while (!(moved && xPos == 10'd0) && n < 60);
    check("wrap_right_reached", int'(n < 60), 1);
    leftRight = 0;
    push(14, 6);
    n = 0;
    do begin @(negedge clock); n++; end while (!moved && n < 20);
    leftRight = 2;
    check("wrap_left_x", int'(xPos), 14);
    repeat (10) @(negedge clock);
    check("wrap_pending", q.size(), 0);
`endif
    reset_n = 0; leftRight = 2; upDown = 2;
    @(negedge clock);
    reset_n = 1;
    repeat (8) @(negedge clock);
    leftRight = 0;
    @(negedge clock);
    leftRight = 2;
    repeat (20) @(negedge clock);
    check("glitch_x", int'(xPos), 8);
    check("glitch_y", int'(yPos), 6);
    enable = 0; leftRight = 1;
    repeat (12) @(negedge clock);
    check("hold_x", int'(xPos), 8);
    push(10, 6);
    enable = 1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      check("pre_move_x", int'(xPos), 8);
      check("pre_move_moved", int'(moved), 0);
    end
    @(negedge clock);
    check("first_move_moved", int'(moved), 1);
    enable = 0; leftRight = 2;
    repeat (10) @(negedge clock);
    check("final_pending", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
